// File: rtl/nv_nvdla_cdma_wt_arb_pkg.sv
// Shared types and constants for the CDMA weight-path arbiter interface.
// The entry struct is common to the sink and the arbiter-side benches.
package nv_nvdla_cdma_wt_arb_pkg;

   localparam int ARB_DW    = 64;
   localparam int ARB_DEPTH = 4;
   localparam int ARB_AW    = 2;
   localparam int ARB_CW    = 8;

   localparam logic SRC_REQ0 = 1'b0;
   localparam logic SRC_REQ1 = 1'b1;

   typedef struct packed {
      logic              src;
      logic [ARB_DW-1:0] pd;
   } arb_entry_t;

endpackage

// File: rtl/nv_nvdla_cdma_wt_arb_sink_fifo.sv
// Generic flop FIFO with occupancy count, full and empty.
// Storage is left unreset; only pointers and count are cleared.
module nv_nvdla_cdma_wt_arb_sink_fifo #(
   parameter int W     = 65,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset_,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/nv_nvdla_cdma_wt_arb_sink.sv
// Responder end of the CDMA weight 2-way WRR arbiter: captures the granted
// payload with its source tag, drains it on valid/ready, back-pressures when full.
module nv_nvdla_cdma_wt_arb_sink
   import nv_nvdla_cdma_wt_arb_pkg::*;
#(
   parameter int DW    = ARB_DW,
   parameter int DEPTH = ARB_DEPTH,
   parameter int AW    = ARB_AW,
   parameter int CW    = ARB_CW
) (
   input  logic          clk,
   input  logic          reset_,
   input  logic          gnt0,
   input  logic          gnt1,
   input  logic [DW-1:0] req0_pd,
   input  logic [DW-1:0] req1_pd,
   output logic          gnt_busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_pd,
   output logic          out_src,
   output logic [CW-1:0] acc_cnt0,
   output logic [CW-1:0] acc_cnt1,
   output logic          gnt_err
);

   logic [AW:0] count;
   logic [AW:0] count_nxt;
   logic        full;
   logic        empty;
   logic        single;
   logic        both;
   logic        push;
   logic        pop;
   logic        src;
   logic [DW:0] din;
   logic [DW:0] dout;

   assign single    = gnt0 ^ gnt1;
   assign both      = gnt0 & gnt1;
   assign push      = single & ~full;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign src       = gnt1 ? SRC_REQ1 : SRC_REQ0;
   assign din       = {src, gnt1 ? req1_pd : req0_pd};
   assign out_src   = dout[DW];
   assign out_pd    = dout[DW-1:0];
   assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

   nv_nvdla_cdma_wt_arb_sink_fifo #(
      .W     (DW+1),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk    (clk),
      .reset_ (reset_),
      .push   (push),
      .din    (din),
      .pop    (pop),
      .dout   (dout),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   // Busy is registered, so it trails the filling push by one cycle.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         gnt_busy <= 1'b0;
         acc_cnt0 <= '0;
         acc_cnt1 <= '0;
         gnt_err  <= 1'b0;
      end else begin
         gnt_busy <= (count_nxt == (AW+1)'(DEPTH));
         if (push && !gnt1) acc_cnt0 <= acc_cnt0 + 1'b1;
         if (push && gnt1)  acc_cnt1 <= acc_cnt1 + 1'b1;
         if (both || ((gnt0 || gnt1) && full)) gnt_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_arb_sink.sv
// Scoreboard bench for the CDMA weight arbiter sink.
// Stimulus queues expected entries; a negedge monitor checks every pop.
module tb_nv_nvdla_cdma_wt_arb_sink;
   import nv_nvdla_cdma_wt_arb_pkg::*;

   logic              clk = 1'b0;
   logic              reset_;
   logic              gnt0;
   logic              gnt1;
   logic [ARB_DW-1:0] req0_pd;
   logic [ARB_DW-1:0] req1_pd;
   logic              gnt_busy;
   logic              out_valid;
   logic              out_ready;
   logic [ARB_DW-1:0] out_pd;
   logic              out_src;
   logic [ARB_CW-1:0] acc_cnt0;
   logic [ARB_CW-1:0] acc_cnt1;
   logic              gnt_err;

   int checks   = 0;
   int failures = 0;

   arb_entry_t exp_q [$];

   nv_nvdla_cdma_wt_arb_sink dut (
      .clk       (clk),
      .reset_    (reset_),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .req0_pd   (req0_pd),
      .req1_pd   (req1_pd),
      .gnt_busy  (gnt_busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pd    (out_pd),
      .out_src   (out_src),
      .acc_cnt0  (acc_cnt0),
      .acc_cnt1  (acc_cnt1),
      .gnt_err   (gnt_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_ && out_valid && out_ready) begin
         arb_entry_t e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected got pd=%h src=%0d", out_pd, out_src);
         end else begin
            e = exp_q.pop_front();
            if (out_pd !== e.pd || out_src !== e.src) begin
               failures++;
               $display("FAIL pop got pd=%h src=%0d want pd=%h src=%0d",
                        out_pd, out_src, e.pd, e.src);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_ = 1'b0;
      exp_q.delete();
      repeat (3) tick();
      reset_ = 1'b1;
   endtask

   // Drive one grant for one cycle; acc says whether the bench expects acceptance.
   task automatic grant(input logic s, input logic [ARB_DW-1:0] pd,
                        input bit acc);
      arb_entry_t e;
      gnt0 = ~s;
      gnt1 = s;
      if (s) req1_pd = pd;
      else   req0_pd = pd;
      if (acc) begin
         e.src = s;
         e.pd  = pd;
         exp_q.push_back(e);
      end
      tick();
      gnt0 = 1'b0;
      gnt1 = 1'b0;
   endtask

   initial begin
      reset_    = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      req0_pd   = '0;
      req1_pd   = '0;
      out_ready = 1'b0;

      // 1: reset
      repeat (3) tick();
      check("rst_busy", 64'(gnt_busy), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_cnt0", 64'(acc_cnt0), 64'd0);
      check("rst_cnt1", 64'(acc_cnt1), 64'd0);
      check("rst_err", 64'(gnt_err), 64'd0);
      reset_ = 1'b1;
      tick();
      check("rel_busy", 64'(gnt_busy), 64'd0);
      check("rel_valid", 64'(out_valid), 64'd0);

      // 2: fill with alternating sources, then drain
      grant(1'b0, 64'hA0, 1'b1);
      check("t2_valid_lat", 64'(out_valid), 64'd1);
      grant(1'b1, 64'hB1, 1'b1);
      grant(1'b0, 64'hA2, 1'b1);
      check("t2_busy_3", 64'(gnt_busy), 64'd0);
      grant(1'b1, 64'hB3, 1'b1);
      check("t2_busy_full", 64'(gnt_busy), 64'd1);
      out_ready = 1'b1;
      tick();
      check("t2_busy_drop", 64'(gnt_busy), 64'd0);
      repeat (4) tick();
      check("t2_drained", 64'(exp_q.size()), 64'd0);
      check("t2_cnt0", 64'(acc_cnt0), 64'd2);
      check("t2_cnt1", 64'(acc_cnt1), 64'd2);

      // 3: steady flow of 300 back-to-back grants
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         grant(1'b0, 64'(i) + 64'h1000, 1'b1);
         gnt0 = 1'b1;
         check("t3_valid", 64'(out_valid), 64'd1);
         check("t3_busy", 64'(gnt_busy), 64'd0);
      end
      gnt0 = 1'b0;
      repeat (3) tick();
      check("t3_cnt0", 64'(acc_cnt0), 64'd44);
      check("t3_drained", 64'(exp_q.size()), 64'd0);

      // 4: both grants at once
      gnt0 = 1'b1;
      gnt1 = 1'b1;
      req0_pd = 64'hDEAD;
      req1_pd = 64'hBEEF;
      tick();
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      check("t4_err", 64'(gnt_err), 64'd1);
      check("t4_cnt0", 64'(acc_cnt0), 64'd44);
      check("t4_cnt1", 64'(acc_cnt1), 64'd0);
      check("t4_nopush", 64'(out_valid), 64'd0);
      repeat (3) tick();
      check("t4_sticky", 64'(gnt_err), 64'd1);

      // 5: grant while full is dropped
      do_reset();
      out_ready = 1'b0;
      check("t5_err_clr", 64'(gnt_err), 64'd0);
      grant(1'b0, 64'hC0, 1'b1);
      grant(1'b1, 64'hC1, 1'b1);
      grant(1'b1, 64'hC2, 1'b1);
      grant(1'b0, 64'hC3, 1'b1);
      check("t5_err_pre", 64'(gnt_err), 64'd0);
      grant(1'b1, 64'hDD, 1'b0);
      check("t5_err", 64'(gnt_err), 64'd1);
      check("t5_cnt1", 64'(acc_cnt1), 64'd2);
      check("t5_busy", 64'(gnt_busy), 64'd1);
      out_ready = 1'b1;
      repeat (5) tick();
      check("t5_drained", 64'(exp_q.size()), 64'd0);
      check("t5_empty", 64'(out_valid), 64'd0);

      // 6: async reset mid-stream
      do_reset();
      out_ready = 1'b0;
      grant(1'b0, 64'h11, 1'b0);
      grant(1'b1, 64'h22, 1'b0);
      check("t6_valid", 64'(out_valid), 64'd1);
      #2;
      reset_ = 1'b0;
      #1;
      check("t6_async", 64'(out_valid), 64'd0);
      tick();
      reset_ = 1'b1;
      tick();
      check("t6_post", 64'(out_valid), 64'd0);
      grant(1'b1, 64'hEE, 1'b1);
      out_ready = 1'b1;
      repeat (2) tick();
      check("t6_drained", 64'(exp_q.size()), 64'd0);
      check("t6_cnt1", 64'(acc_cnt1), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
